// File: rtl/bike_div_pkg.sv
// ============================================================================
// Module : bike_div_pkg
// Brief  : Shared types and constants for the divider arbiter slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bike_div_pkg;

  localparam int DEF_WIDTH = 16;

  // Quotient reported when a division by zero is short-circuited.
  localparam logic [DEF_WIDTH-1:0] DIV_SAT = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_BUSY  = 3'd2,
    WAIT_READY = 3'd3,
    DELIVER    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_arbiter_if.sv
// ============================================================================
// Module : div_arbiter_if
// Brief  : Requester bus and divider handshake bundle for div_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface div_arbiter_if
  import bike_div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_result;
  logic                     div_start;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic [SEL_W-1:0]         div_select;
  logic                     div_busy;
  logic                     div_ready;
  logic [WIDTH-1:0]         div_result;
  logic                     arb_busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_dividend, req_divisor, div_busy, div_ready, div_result,
    output resp_valid, resp_result, div_start, div_dividend, div_divisor,
           div_select, arb_busy
  );

  // Requesters plus divider side.
  modport slave (
    output req_valid, req_dividend, req_divisor, div_busy, div_ready, div_result,
    input  resp_valid, resp_result, div_start, div_dividend, div_divisor,
           div_select, arb_busy
  );

endinterface

`default_nettype wire

// File: rtl/div_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import bike_div_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grant,
  output logic               any_req
);

  int w_best;
  int w_dist;

  // Smallest circular distance from ptr wins.
  always_comb begin
    grant   = '0;
    w_best  = NUM_REQ;
    w_dist  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_REQ - int'(ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          grant  = SEL_W'(i);
        end
      end
    end
    any_req = |req;
  end

endmodule

`default_nettype wire

// File: rtl/div_arbiter.sv
// ============================================================================
// Module : div_arbiter
// Brief  : Round-robin sharing of one sequential divider among NUM_REQ users.
//          Optional: DIV_ZERO_BYPASS_EN answers zero divisors with all ones
//          without starting the divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_arbiter
  import bike_div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  div_arbiter_if.master bus
);

  localparam logic [SEL_W-1:0] c_last = SEL_W'(NUM_REQ - 1);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0]   r_dividend, w_dividend_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic [SEL_W-1:0]   r_select, w_select_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic [NUM_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic               r_start, w_start_nxt;

  logic [SEL_W-1:0]   w_grant;
  logic               w_any;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_bypass;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .any_req (w_any)
  );

  assign w_onehot = NUM_REQ'(1) << r_select;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = (r_divisor == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_dividend_nxt   = r_dividend;
    w_divisor_nxt    = r_divisor;
    w_select_nxt     = r_select;
    w_result_nxt     = r_result;
    w_resp_valid_nxt = '0;
    w_start_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_dividend_nxt = bus.req_dividend[int'(w_grant)*WIDTH +: WIDTH];
          w_divisor_nxt  = bus.req_divisor[int'(w_grant)*WIDTH +: WIDTH];
          w_select_nxt   = w_grant;
          w_ptr_nxt      = (w_grant == c_last) ? '0 : (w_grant + 1'b1);
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (w_bypass) begin
          w_result_nxt     = {WIDTH{1'b1}};
          w_resp_valid_nxt = w_onehot;
          w_state_nxt      = DELIVER;
        end else if (!bus.div_busy) begin
          w_start_nxt = 1'b1;
          w_state_nxt = WAIT_BUSY;
        end
      end
      // A ready seen together with busy here is deliberately ignored.
      WAIT_BUSY: begin
        if (bus.div_busy) begin
          w_state_nxt = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (bus.div_ready) begin
          w_result_nxt     = bus.div_result;
          w_resp_valid_nxt = w_onehot;
          w_state_nxt      = DELIVER;
        end
      end
      DELIVER: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_select     <= '0;
      r_result     <= '0;
      r_resp_valid <= '0;
      r_start      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_dividend   <= w_dividend_nxt;
      r_divisor    <= w_divisor_nxt;
      r_select     <= w_select_nxt;
      r_result     <= w_result_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_start      <= w_start_nxt;
    end
  end

  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_result  = r_result;
  assign bus.div_start    = r_start;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;
  assign bus.div_select   = r_select;
  assign bus.arb_busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
// ============================================================================
// Module : tb_div_arbiter
// Brief  : Directed table-driven bench for div_arbiter with a divider model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_div_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(16), .NUM_REQ(3), .SEL_W(2)) bus ();

  div_arbiter #(.WIDTH(16), .NUM_REQ(3), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Divider model: busy for three cycles after start, then a one-cycle ready.
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  logic [1:0]  m_cnt = 2'd0;
  logic [15:0] m_q = 16'd0;
  logic        force_busy = 1'b0;

  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (bus.div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 2'd3;
      m_q    <= (bus.div_divisor == 16'd0) ? 16'hFFFF : bus.div_dividend / bus.div_divisor;
    end else if (m_busy) begin
      if (m_cnt == 2'd1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end
      m_cnt <= m_cnt - 2'd1;
    end
  end

  assign bus.div_busy   = m_busy | force_busy;
  assign bus.div_ready  = m_ready;
  assign bus.div_result = m_q;

  typedef struct {
    logic [2:0]       req;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [1:0]       sel;
    logic [15:0]      q;
    logic             st;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur = -1;

  function automatic vec_t mk(input logic [2:0] req,
                              input logic [15:0] a2, a1, a0, b2, b1, b0,
                              input logic [1:0] sel, input logic [15:0] q,
                              input logic st);
    vec_t v;
    v.req = req;
    v.a   = {a2, a1, a0};
    v.b   = {b2, b1, b0};
    v.sel = sel;
    v.q   = q;
    v.st  = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", nm, cur, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_resp(input logic [1:0] sel, input logic [15:0] q);
    int n;
    n = 0;
    while (bus.resp_valid == 3'b000 && n < 50) begin
      cyc();
      n++;
    end
    chk("resp_valid", bus.resp_valid, 32'(3'b001 << sel));
    chk("resp_result", bus.resp_result, q);
    chk("select_hold", bus.div_select, sel);
    bus.req_valid[sel] = 1'b0;
    cyc();
    chk("resp_pulse_end", bus.resp_valid, 0);
    chk("back_to_idle", bus.arb_busy, 0);
  endtask

  task automatic run_txn(input vec_t v);
    bus.req_dividend = v.a;
    bus.req_divisor  = v.b;
    bus.req_valid    = v.req;
    cyc();
    chk("start_early", bus.div_start, 0);
    chk("arb_busy", bus.arb_busy, 1);
    cyc();
    chk("start_lat2", bus.div_start, v.st);
    chk("select", bus.div_select, v.sel);
    chk("dividend", bus.div_dividend, v.a[v.sel]);
    chk("divisor", bus.div_divisor, v.b[v.sel]);
    wait_resp(v.sel, v.q);
  endtask

  task automatic wait_div_busy();
    int n;
    n = 0;
    while (!bus.div_busy && n < 20) begin
      cyc();
      n++;
    end
    chk("div_busy_seen", bus.div_busy, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bus.resp_valid, bus.resp_result, bus.div_start, bus.div_dividend[11:0],
             bus.arb_busy}, 0);
    chk({nm, "_ops"}, {bus.div_dividend, bus.div_divisor}, 0);
    chk({nm, "_sel"}, bus.div_select, 0);
  endtask

  initial begin
    vecs[0] = mk(3'b111, 16'd65535, 16'd500, 16'd1000, 16'd255, 16'd7, 16'd10, 2'd0, 16'd100, 1'b1);
    vecs[1] = mk(3'b111, 16'd65535, 16'd500, 16'd1000, 16'd255, 16'd7, 16'd10, 2'd1, 16'd71, 1'b1);
    vecs[2] = mk(3'b111, 16'd65535, 16'd500, 16'd1000, 16'd255, 16'd7, 16'd10, 2'd2, 16'd257, 1'b1);
    vecs[3] = mk(3'b111, 16'd65535, 16'd500, 16'd12345, 16'd255, 16'd7, 16'd5, 2'd0, 16'd2469, 1'b1);
    vecs[4] = mk(3'b001, 16'd0, 16'd0, 16'd36000, 16'd1, 16'd1, 16'd1200, 2'd0, 16'd30, 1'b1);
    vecs[5] = mk(3'b100, 16'd40000, 16'd0, 16'd0, 16'd16, 16'd1, 16'd1, 2'd2, 16'd2500, 1'b1);
    vecs[6] = mk(3'b010, 16'd0, 16'd100, 16'd0, 16'd1, 16'd3, 16'd1, 2'd1, 16'd33, 1'b1);
    vecs[7] = mk(3'b011, 16'd0, 16'd50, 16'd7, 16'd1, 16'd2, 16'd9, 2'd0, 16'd0, 1'b1);
`ifdef DIV_ZERO_BYPASS_EN
    vecs[8] = mk(3'b001, 16'd0, 16'd0, 16'd1234, 16'd1, 16'd1, 16'd0, 2'd0, 16'hFFFF, 1'b0);
`else
    vecs[8] = mk(3'b001, 16'd0, 16'd0, 16'd1234, 16'd1, 16'd1, 16'd0, 2'd0, 16'hFFFF, 1'b1);
`endif

    rst_n            = 1'b0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) cyc();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      cur = i;
      run_txn(vecs[i]);
    end

    // Divider busy before grant: hold in ISSUE, operands frozen. ptr is 1.
    cur = 100;
    force_busy       = 1'b1;
    bus.req_dividend = {16'd0, 16'd0, 16'd36000};
    bus.req_divisor  = {16'd1, 16'd1, 16'd1200};
    bus.req_valid    = 3'b001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("busy_hold_no_start", bus.div_start, 0);
      if (i == 1) begin
        bus.req_dividend = {16'd0, 16'd0, 16'd999};
        bus.req_divisor  = {16'd1, 16'd1, 16'd3};
      end
    end
    chk("busy_hold_arb_busy", bus.arb_busy, 1);
    chk("busy_hold_ops", {bus.div_dividend, bus.div_divisor}, {16'd36000, 16'd1200});
    force_busy = 1'b0;
    cyc();
    chk("busy_release_start", bus.div_start, 1);
    wait_resp(2'd0, 16'd30);

    // Requester 1 drops during WAIT_READY; requester 2 follows. ptr is 1.
    cur = 200;
    bus.req_dividend = {16'd65535, 16'd500, 16'd0};
    bus.req_divisor  = {16'd255, 16'd7, 16'd1};
    bus.req_valid    = 3'b110;
    wait_div_busy();
    cyc();
    bus.req_valid[1] = 1'b0;
    wait_resp(2'd1, 16'd71);
    cyc();
    cyc();
    chk("next_grant_start", bus.div_start, 1);
    chk("next_grant_sel", bus.div_select, 2);
    wait_resp(2'd2, 16'd257);

    // Reset while waiting for ready: the result is dropped. ptr is 0.
    cur = 300;
    bus.req_dividend = {16'd0, 16'd0, 16'd1000};
    bus.req_divisor  = {16'd1, 16'd1, 16'd10};
    bus.req_valid    = 3'b001;
    wait_div_busy();
    cyc();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("reset_no_resp", bus.resp_valid, 0);
    end
    rst_n = 1'b1;
    cyc();
    chk_all_zero("after_reset");
    // Pointer must be back at 0: requesters 0 and 1 both ask, 0 wins.
    cur = 301;
    run_txn(mk(3'b011, 16'd0, 16'd9, 16'd40000, 16'd1, 16'd3, 16'd16, 2'd0, 16'd2500, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
